// File: rtl/svc_sram_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : svc_sram_pin_ctrl
// Description : Asynchronous SRAM pin controller. Accepts one read or write
//               command at a time, times the strobe pulses with a counter, and
//               returns read data with the command's meta tag. Every pin is
//               driven straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module svc_sram_pin_ctrl #(
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_META_WIDTH = 4,
    parameter int RD_CYCLES       = 2,
    parameter int WR_CYCLES       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sram_cmd_valid,
    output logic                         sram_cmd_ready,
    input  logic                         sram_cmd_wr_en,
    input  logic [SRAM_ADDR_WIDTH-1:0]   sram_cmd_addr,
    input  logic [SRAM_META_WIDTH-1:0]   sram_cmd_meta,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_cmd_wr_data,
    input  logic [SRAM_DATA_WIDTH/8-1:0] sram_cmd_wr_strb,
    output logic                         sram_rd_resp_valid,
    input  logic                         sram_rd_resp_ready,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_rd_resp_data,
    output logic [SRAM_META_WIDTH-1:0]   sram_rd_resp_meta,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_io_addr,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_io_data_o,
    output logic                         sram_io_data_oe,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_io_data_i,
    output logic                         sram_io_ce_n,
    output logic                         sram_io_we_n,
    output logic                         sram_io_oe_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_io_be_n
);

    localparam int BW    = SRAM_DATA_WIDTH / 8;
    localparam int MAXC  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [SRAM_META_WIDTH-1:0] meta_q;
    logic                       cmd_accept;
    logic                       resp_pop;

    // A pending, unconsumed response blocks new commands so it can never be overwritten.
    assign sram_cmd_ready = (state == IDLE) && !(sram_rd_resp_valid && !sram_rd_resp_ready) && !rst;
    assign cmd_accept     = sram_cmd_valid && sram_cmd_ready;
    assign resp_pop       = sram_rd_resp_valid && sram_rd_resp_ready;

    // Command FSM: pin levels are set one edge ahead so each phase sees them from its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            meta_q             <= '0;
            sram_rd_resp_valid <= 1'b0;
            sram_rd_resp_data  <= '0;
            sram_rd_resp_meta  <= '0;
            sram_io_addr       <= '0;
            sram_io_data_o     <= '0;
            sram_io_data_oe    <= 1'b0;
            sram_io_ce_n       <= 1'b1;
            sram_io_we_n       <= 1'b1;
            sram_io_oe_n       <= 1'b1;
            sram_io_be_n       <= {BW{1'b1}};
        end else begin
            // Consumption clears valid; a capture in the RD branch below overrides it.
            if (resp_pop) begin
                sram_rd_resp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        sram_io_addr   <= sram_cmd_addr;
                        sram_io_data_o <= sram_cmd_wr_data;
                        meta_q         <= sram_cmd_meta;
                        sram_io_ce_n   <= 1'b0;
                        if (sram_cmd_wr_en) begin
                            state           <= WR;
                            cnt             <= CNT_W'(WR_CYCLES - 1);
                            // An all-zero strobe keeps the timing but never pulses we_n.
                            sram_io_we_n    <= (sram_cmd_wr_strb == '0);
                            sram_io_oe_n    <= 1'b1;
                            sram_io_data_oe <= 1'b1;
                            sram_io_be_n    <= ~sram_cmd_wr_strb;
                        end else begin
                            state           <= RD;
                            cnt             <= CNT_W'(RD_CYCLES - 1);
                            sram_io_we_n    <= 1'b1;
                            sram_io_oe_n    <= 1'b0;
                            sram_io_data_oe <= 1'b0;
                            sram_io_be_n    <= '0;
                        end
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        // Keep driving data through RECOVER for hold time.
                        state        <= RECOVER;
                        sram_io_ce_n <= 1'b1;
                        sram_io_we_n <= 1'b1;
                        sram_io_be_n <= {BW{1'b1}};
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        state              <= RECOVER;
                        sram_rd_resp_valid <= 1'b1;
                        sram_rd_resp_data  <= sram_io_data_i;
                        sram_rd_resp_meta  <= meta_q;
                        sram_io_ce_n       <= 1'b1;
                        sram_io_oe_n       <= 1'b1;
                        sram_io_be_n       <= {BW{1'b1}};
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    state           <= IDLE;
                    sram_io_data_oe <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svc_sram_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_svc_sram_pin_ctrl
// Description : Directed self-checking bench for svc_sram_pin_ctrl with a
//               pin-level SRAM model and a read-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svc_sram_pin_ctrl;

    localparam int SAW = 8;
    localparam int DW  = 16;
    localparam int MW  = 4;
    localparam int BW  = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_wr_en = 1'b0;
    logic [SAW-1:0]  cmd_addr = '0;
    logic [MW-1:0]   cmd_meta = '0;
    logic [DW-1:0]   cmd_wr_data = '0;
    logic [BW-1:0]   cmd_wr_strb = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_data;
    logic [MW-1:0]   resp_meta;
    logic [SAW-1:0]  io_addr;
    logic [DW-1:0]   io_data_o;
    logic            io_data_oe;
    logic [DW-1:0]   io_data_i;
    logic            io_ce_n;
    logic            io_we_n;
    logic            io_oe_n;
    logic [BW-1:0]   io_be_n;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]      sram_mem [0:255];   // pin-level device contents
    logic [DW-1:0]      shadow   [0:255];   // bench's expected contents
    logic [MW+DW-1:0]   sb_q [$];           // expected {meta, data} per read

    svc_sram_pin_ctrl #(
        .SRAM_ADDR_WIDTH (SAW),
        .SRAM_DATA_WIDTH (DW),
        .SRAM_META_WIDTH (MW),
        .RD_CYCLES       (2),
        .WR_CYCLES       (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sram_cmd_valid     (cmd_valid),
        .sram_cmd_ready     (cmd_ready),
        .sram_cmd_wr_en     (cmd_wr_en),
        .sram_cmd_addr      (cmd_addr),
        .sram_cmd_meta      (cmd_meta),
        .sram_cmd_wr_data   (cmd_wr_data),
        .sram_cmd_wr_strb   (cmd_wr_strb),
        .sram_rd_resp_valid (resp_valid),
        .sram_rd_resp_ready (resp_ready),
        .sram_rd_resp_data  (resp_data),
        .sram_rd_resp_meta  (resp_meta),
        .sram_io_addr       (io_addr),
        .sram_io_data_o     (io_data_o),
        .sram_io_data_oe    (io_data_oe),
        .sram_io_data_i     (io_data_i),
        .sram_io_ce_n       (io_ce_n),
        .sram_io_we_n       (io_we_n),
        .sram_io_oe_n       (io_oe_n),
        .sram_io_be_n       (io_be_n)
    );

    always #5 clk = ~clk;

    // SRAM device: drives the bus only while selected and output-enabled.
    assign io_data_i = (!io_ce_n && !io_oe_n) ? sram_mem[io_addr] : 16'hDEAD;

    // SRAM device: byte-masked write while ce_n and we_n are both low.
    always @(posedge clk) begin
        if (!io_ce_n && !io_we_n && io_data_oe) begin
            for (int b = 0; b < BW; b++) begin
                if (!io_be_n[b]) sram_mem[io_addr][b*8 +: 8] <= io_data_o[b*8 +: 8];
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin group {ce_n, we_n, oe_n, data_oe, be_n}
    function automatic logic [31:0] pins();
        return 32'({io_ce_n, io_we_n, io_oe_n, io_data_oe, io_be_n});
    endfunction

    function automatic logic [31:0] mk_pins(input logic ce_n, input logic we_n, input logic oe_n,
                                            input logic oe, input logic [BW-1:0] be_n);
        return 32'({ce_n, we_n, oe_n, oe, be_n});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pins"},      pins(), mk_pins(1'b1, 1'b1, 1'b1, 1'b0, 2'b11));
        check({tag, "_addr"},      32'(io_addr), 32'h0);
        check({tag, "_data_o"},    32'(io_data_o), 32'h0);
        check({tag, "_rvalid"},    32'(resp_valid), 32'h0);
        check({tag, "_rdata"},     32'(resp_data), 32'h0);
        check({tag, "_rmeta"},     32'(resp_meta), 32'h0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
    endtask

    task automatic do_write(input logic [SAW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] s);
        cmd_valid = 1'b1; cmd_wr_en = 1'b1; cmd_addr = a; cmd_wr_data = d; cmd_wr_strb = s; cmd_meta = '0;
        check("wr_accept_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        for (int b = 0; b < BW; b++) if (s[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
        for (int c = 0; c < 2; c++) begin
            check("wr_pins",   pins(), mk_pins(1'b0, (s == '0), 1'b1, 1'b1, ~s));
            check("wr_addr",   32'(io_addr), 32'(a));
            check("wr_data_o", 32'(io_data_o), 32'(d));
            check("wr_busy",   32'(cmd_ready), 32'h0);
            tick();
        end
        check("wr_recover_pins", pins(), mk_pins(1'b1, 1'b1, 1'b1, 1'b1, 2'b11));
        check("wr_recover_addr", 32'(io_addr), 32'(a));
        check("wr_recover_busy", 32'(cmd_ready), 32'h0);
        tick();
        check("wr_idle_pins",  pins(), mk_pins(1'b1, 1'b1, 1'b1, 1'b0, 2'b11));
        check("wr_idle_ready", 32'(cmd_ready), 32'h1);
    endtask

    task automatic do_read(input logic [SAW-1:0] a, input logic [MW-1:0] m, input int hold);
        logic [MW+DW-1:0] exp;
        sb_q.push_back({m, shadow[a]});
        cmd_valid = 1'b1; cmd_wr_en = 1'b0; cmd_addr = a; cmd_meta = m; cmd_wr_strb = '0;
        check("rd_accept_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("rd_pins",   pins(), mk_pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
            check("rd_addr",   32'(io_addr), 32'(a));
            check("rd_rvalid_early", 32'(resp_valid), 32'h0);
            tick();
        end
        check("rd_rvalid", 32'(resp_valid), 32'h1);
        check("rd_recover_pins", pins(), mk_pins(1'b1, 1'b1, 1'b1, 1'b0, 2'b11));
        if (sb_q.size() == 0) begin
            check("rd_sb_nonempty", 32'h0, 32'h1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check("rd_data", 32'(resp_data), 32'(exp[DW-1:0]));
        check("rd_meta", 32'(resp_meta), 32'(exp[MW+DW-1:DW]));
        for (int c = 0; c < hold; c++) begin
            resp_ready = 1'b0;
            tick();
            check("rd_hold_valid", 32'(resp_valid), 32'h1);
            check("rd_hold_data",  32'(resp_data), 32'(exp[DW-1:0]));
            check("rd_hold_meta",  32'(resp_meta), 32'(exp[MW+DW-1:DW]));
            check("rd_hold_block", 32'(cmd_ready), 32'h0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("rd_consumed_valid", 32'(resp_valid), 32'h0);
        check("rd_consumed_ready", 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("post_reset_ready", 32'(cmd_ready), 32'h1);

        // Full-word write then read-back with immediate and stalled consumer
        do_write(8'h12, 16'hD000, 2'b11);
        do_read(8'h12, 4'hB, 0);
        do_read(8'h12, 4'h5, 4);

        // Partial strobe, then an all-zero strobe that must not write
        do_write(8'h20, 16'hABCD, 2'b01);
        do_write(8'h20, 16'h1111, 2'b00);
        do_read(8'h20, 4'h3, 0);

        // Reset in the second RD cycle aborts without a response
        cmd_valid = 1'b1; cmd_wr_en = 1'b0; cmd_addr = 8'h12; cmd_meta = 4'h7;
        check("abort_accept_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_in_rd", pins(), mk_pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        tick();
        check("abort_ready_after", 32'(cmd_ready), 32'h1);
        check("abort_no_resp",     32'(resp_valid), 32'h0);
        tick();
        check("abort_still_no_resp", 32'(resp_valid), 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svc_sram_pin_ctrl.md
SVC_SRAM_PIN_CTRL -- requirements
Module: svc_sram_pin_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SRAM_ADDR_WIDTH, 18, word address width (SAW)
- SRAM_DATA_WIDTH, 16, data width (DW, multiple of 8)
- SRAM_META_WIDTH, 4, opaque meta width (MW)
- RD_CYCLES, 2, cycles oe_n is held low per read (>=1)
- WR_CYCLES, 2, cycles we_n is held low per write (>=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. The block has one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sram_cmd_valid  in  1  command valid
- sram_cmd_ready  out  1  command accepted when valid&&ready
- sram_cmd_wr_en  in  1  1=write, 0=read
- sram_cmd_addr  in  SAW  word address
- sram_cmd_meta  in  MW  returned with read response
- sram_cmd_wr_data  in  DW  write data
- sram_cmd_wr_strb  in  DW/8  byte strobes
- sram_rd_resp_valid  out  1  read data valid
- sram_rd_resp_ready  in  1  consumer ready
- sram_rd_resp_data  out  DW  read data
- sram_rd_resp_meta  out  MW  meta of the originating read
- sram_io_addr  out  SAW  pin address
- sram_io_data_o  out  DW  pin write data
- sram_io_data_oe  out  1  data bus drive enable
- sram_io_data_i  in  DW  pin read data
- sram_io_ce_n  out  1  chip enable, active low
- sram_io_we_n  out  1  write enable, active low
- sram_io_oe_n  out  1  output enable, active low
- sram_io_be_n  out  DW/8  byte enables, active low

Function
REQ-003 All sram_io_* outputs SHALL be driven from registers, with no combinational path from any input.
REQ-004 The FSM SHALL have the states IDLE, WR, RD and RECOVER; a counter SHALL time WR and RD.
REQ-005 sram_cmd_ready SHALL equal (state==IDLE) && !(sram_rd_resp_valid && !sram_rd_resp_ready) && !rst.
REQ-006 On accept: latch addr, data, strb and meta; go to WR (wr_en=1) or RD (wr_en=0); load counter with WR_CYCLES-1 or RD_CYCLES-1.
REQ-007 WR state: ce_n=0, we_n=0, oe_n=1, data_oe=1, be_n=~strb, for exactly WR_CYCLES cycles, then RECOVER.
REQ-008 A write with strb==0 SHALL occupy identical timing but hold we_n=1 throughout.
REQ-009 RD state: ce_n=0, oe_n=0, we_n=1, data_oe=0, be_n=0, for exactly RD_CYCLES cycles; at the clock edge ending the last RD cycle, capture sram_io_data_i into resp_data and meta into resp_meta, set rd_resp_valid=1, then go to RECOVER.
REQ-010 RECOVER SHALL last 1 cycle, with we_n=1, oe_n=1, addr held, and data_oe=1 only if the previous op was a write (data hold / bus turnaround); ce_n=1; then IDLE.
REQ-011 IDLE: ce_n=we_n=oe_n=1, data_oe=0, be_n all 1.
REQ-012 Throughput SHALL be a write every WR_CYCLES+1 cycles and a read every RD_CYCLES+1 cycles, with back-to-back accept at the IDLE cycle following RECOVER.
REQ-013 sram_rd_resp_valid SHALL clear on valid&&ready unless a new capture occurs at the same edge, in which case it stays 1 with the new data; data and meta SHALL stay stable while valid&&!ready.
REQ-014 A read SHALL NOT be accepted while an unconsumed response is pending (REQ-005), so no response is ever overwritten.
REQ-015 Address and data SHALL pass unmodified; no arithmetic on addresses.

Reset
REQ-016 rst SHALL set state=IDLE, counter=0, sram_rd_resp_valid=0, sram_cmd_ready=0, ce_n=we_n=oe_n=1, data_oe=0, be_n all 1, addr/data/resp_data/resp_meta=0.
REQ-017 rst asserted mid-WR or mid-RD SHALL abort the op at the next edge with no response generated.

Verification (DW=16, SAW=8, MW=4, RD_CYCLES=2, WR_CYCLES=2)
REQ-018 Reset: after rst, check every output against REQ-016; sram_cmd_ready=1 the cycle after rst deasserts.
REQ-019 Write addr=0x12, data=0xD000, strb=2'b11 -> we_n low 2 cycles with addr=0x12, data_o=0xD000, be_n=2'b00; RECOVER with data_oe=1; ready again 3 cycles after accept.
REQ-020 Read addr=0x12, meta=0xB, model drives 0xD000 -> rd_resp_valid=1, data=0xD000, meta=0xB, 2 cycles after accept; data_oe=0 throughout.
REQ-021 Read with rd_resp_ready=0 for 4 cycles -> response held stable, cmd_ready=0 in IDLE; ready=1 -> response consumed and cmd_ready=1 the next cycle.
REQ-022 Write strb=2'b01, then strb=2'b00 -> be_n=2'b10, then we_n stays 1 for the full 2 cycles.
REQ-023 Assert rst during the second RD cycle -> no rd_resp_valid; outputs match REQ-016 at the next edge.
